mem_bist_ctrl: RTL

//  Hardware memory self-test controller driving the 32x8 memory over the read/write/addr/data bus.

---
 rtl/mem_bist_pkg.sv | 32 +++
 rtl/mem_bist_rd_pipe.sv | 54 +++++
 rtl/mem_bist_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_bist_pkg.sv
// Purpose : shared types, limits and pattern function for the memory BIST controller.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: state_e (controller FSM), phase_e (pattern pass), MAX_RD_LAT, exp_data().
package mem_bist_pkg;

   // Deepest read pipe the controller supports.
   localparam int MAX_RD_LAT = 4;

   typedef enum logic [2:0] {
      IDLE,
      CLR_WR,
      CLR_RD,
      CLR_DRN,
      ADR_WR,
      ADR_RD,
      ADR_DRN,
      DONE
   } state_e;

   typedef enum logic {
      PH_CLR,
      PH_ADR
   } phase_e;

   // Pattern value for an address: all-zero in the clear pass, the address
   // itself in the data=address pass. Caller truncates to the data width.
   function automatic logic [31:0] exp_data(input phase_e phase, input logic [31:0] addr);
      return (phase == PH_ADR) ? addr : 32'd0;
   endfunction

endpackage

// File: rtl/mem_bist_rd_pipe.sv
// Purpose : tracks outstanding reads (valid/addr/expected) so each returning word can be checked.
// Latency : DEPTH clocks from vld_i to vld_o.
// Backpr. : none; one entry per clock, flush_i drops everything in flight.
// Ports   : clk, rst_n, flush_i, vld_i/addr_i/exp_i (new read), vld_o/addr_o/exp_o (read due now).
module mem_bist_rd_pipe
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              vld_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] exp_i,
   output logic              vld_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] exp_o
);

   // Clamp so an out-of-range depth still elaborates to something sane.
   localparam int D = (DEPTH > MAX_RD_LAT) ? MAX_RD_LAT : ((DEPTH < 1) ? 1 : DEPTH);

   logic [D-1:0]      vld_q;
   logic [ADDR_W-1:0] addr_q [D];
   logic [DATA_W-1:0] exp_q  [D];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < D; i++) begin
            addr_q[i] <= '0;
            exp_q[i]  <= '0;
         end
      end else begin
         // Flush also blocks the entry being pushed on the same edge.
         vld_q[0]  <= vld_i & ~flush_i;
         addr_q[0] <= addr_i;
         exp_q[0]  <= exp_i;
         for (int i = 1; i < D; i++) begin
            vld_q[i]  <= vld_q[i-1] & ~flush_i;
            addr_q[i] <= addr_q[i-1];
            exp_q[i]  <= exp_q[i-1];
         end
      end
   end

   assign vld_o  = vld_q[D-1];
   assign addr_o = addr_q[D-1];
   assign exp_o  = exp_q[D-1];

endmodule

// File: rtl/mem_bist_ctrl.sv
// Purpose : memory self-test: clear pass (write/read 0) then data=address pass; counts misses, keeps first.
// Latency : start to done = 4*2**ADDR_W + 2*RD_LAT + 1 clocks.
// Backpr. : none; the memory must accept one access per clock. start is ignored while busy.
// Ports   : clk, rst_n, start -> busy, done, pass, err_count, fail_addr, fail_data;
//           memory bus mem_write/mem_read/mem_addr/mem_data_in (registered), mem_data_out (read data).
// Option  : define STOP_ON_FAIL_EN to end the test on the first mismatch.
module mem_bist_ctrl
   import mem_bist_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W+1:0] err_count,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic              mem_write,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out
);

   localparam int LAT = (RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT : ((RD_LAT < 1) ? 1 : RD_LAT);
   localparam logic [ADDR_W-1:0] CNT_MAX  = '1;
   localparam logic [ADDR_W-1:0] DRN_LAST = ADDR_W'(LAT - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W+1:0] err_q, err_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [DATA_W-1:0] fail_data_q, fail_data_d;
   logic              done_q, done_d, pass_q, pass_d, busy_q, busy_d;
   logic              mem_write_q, mem_write_d, mem_read_q, mem_read_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
   logic [DATA_W-1:0] exp_q, exp_d;

   logic              flush;
   logic              pipe_vld;
   logic [ADDR_W-1:0] pipe_addr;
   logic [DATA_W-1:0] pipe_exp;
   logic              mismatch;

   function automatic logic [DATA_W-1:0] pattern(input state_e s, input logic [ADDR_W-1:0] a);
      logic [31:0] full;
      full = exp_data((s == ADR_WR || s == ADR_RD) ? PH_ADR : PH_CLR, 32'(a));
      return full[DATA_W-1:0];
   endfunction

   // The pipe is fed from the registered bus, so its output lines up with
   // the edge where the memory's read data is valid.
   mem_bist_rd_pipe #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush),
      .vld_i   (mem_read_q),
      .addr_i  (mem_addr_q),
      .exp_i   (exp_q),
      .vld_o   (pipe_vld),
      .addr_o  (pipe_addr),
      .exp_o   (pipe_exp)
   );

   // Case inequality so an X/Z from the memory is counted as a miss.
   assign mismatch = pipe_vld && (mem_data_out !== pipe_exp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         err_q         <= '0;
         fail_addr_q   <= '0;
         fail_data_q   <= '0;
         done_q        <= 1'b0;
         pass_q        <= 1'b0;
         busy_q        <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_read_q    <= 1'b0;
         mem_addr_q    <= '0;
         mem_data_in_q <= '0;
         exp_q         <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         err_q         <= err_d;
         fail_addr_q   <= fail_addr_d;
         fail_data_q   <= fail_data_d;
         done_q        <= done_d;
         pass_q        <= pass_d;
         busy_q        <= busy_d;
         mem_write_q   <= mem_write_d;
         mem_read_q    <= mem_read_d;
         mem_addr_q    <= mem_addr_d;
         mem_data_in_q <= mem_data_in_d;
         exp_q         <= exp_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      err_d         = err_q;
      fail_addr_d   = fail_addr_q;
      fail_data_d   = fail_data_q;
      done_d        = done_q;
      pass_d        = pass_q;
      flush         = 1'b0;
      mem_write_d   = 1'b0;
      mem_read_d    = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_data_in_d = '0;
      exp_d         = '0;

      if (mismatch) begin
         if (err_q != '1) err_d = err_q + 1'b1;
         if (err_q == '0) begin
            fail_addr_d = pipe_addr;
            fail_data_d = mem_data_out;
         end
      end

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = CLR_WR;
               cnt_d       = '0;
               err_d       = '0;
               fail_addr_d = '0;
               fail_data_d = '0;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               flush       = 1'b1;
            end
         end
         CLR_WR, ADR_WR: begin
            if (cnt_q == CNT_MAX) begin
               cnt_d   = '0;
               state_d = (state_q == CLR_WR) ? CLR_RD : ADR_RD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CLR_RD, ADR_RD: begin
            if (cnt_q == CNT_MAX) begin
               cnt_d   = '0;
               state_d = (state_q == CLR_RD) ? CLR_DRN : ADR_DRN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CLR_DRN, ADR_DRN: begin
            // The counter doubles as the drain timer.
            if (cnt_q == DRN_LAST) begin
               cnt_d   = '0;
               state_d = (state_q == CLR_DRN) ? ADR_WR : DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef STOP_ON_FAIL_EN
      if (mismatch) begin
         state_d = DONE;
         flush   = 1'b1;
      end
`endif

      if (state_d == DONE && state_q != DONE) begin
         done_d = 1'b1;
         pass_d = (err_d == '0);
      end

      // Bus outputs are decoded from the next state so they register in step with it.
      case (state_d)
         CLR_WR, ADR_WR: begin
            mem_write_d   = 1'b1;
            mem_addr_d    = cnt_d;
            mem_data_in_d = pattern(state_d, cnt_d);
         end
         CLR_RD, ADR_RD: begin
            mem_read_d = 1'b1;
            mem_addr_d = cnt_d;
            exp_d      = pattern(state_d, cnt_d);
         end
         default: ;
      endcase

      busy_d = (state_d != IDLE) && (state_d != DONE);
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign err_count   = err_q;
   assign fail_addr   = fail_addr_q;
   assign fail_data   = fail_data_q;
   assign mem_write   = mem_write_q;
   assign mem_read    = mem_read_q;
   assign mem_addr    = mem_addr_q;
   assign mem_data_in = mem_data_in_q;

endmodule
